// File: rtl/tl_copy_engine.sv
// tl_copy_engine
//   Single-outstanding TileLink-UL initiator that copies a block of 32-bit
//   words from src to dst, one word at a time (Get, then PutFullData).
//
// Ports
//   clock       sole clock, rising edge
//   reset_n     asynchronous active-low reset
//   start       one-cycle copy request, only looked at in IDLE
//   src_addr    source byte address (bits [1:0] ignored)
//   dst_addr    destination byte address (bits [1:0] ignored)
//   word_count  number of words to copy (0 = no bus traffic)
//   busy        high in every state except IDLE
//   done        one-cycle pulse when a copy ends (ok or aborted)
//   error       sticky abort flag, cleared by the next accepted start
//   bus_tla     A channel toward the responder (a_ready = our D-ready, tied 1)
//   bus_tld     D channel from the responder (d_ready = responder's A-ready)

package tl_pkg;

    localparam logic [2:0] OP_PUT_FULL = 3'd0;
    localparam logic [2:0] OP_GET      = 3'd4;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [2:0]  a_size;
        logic [3:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        a_ready;   // initiator ready for D beats
    } tilelink_a;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [1:0]  d_param;
        logic [2:0]  d_size;
        logic [3:0]  d_source;
        logic [31:0] d_data;
        logic        d_error;
        logic        d_ready;   // responder ready for A beats
    } tilelink_d;

endpackage

module tl_copy_engine
    import tl_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] src_addr,
    input  logic [31:0] dst_addr,
    input  logic [15:0] word_count,
    output logic        busy,
    output logic        done,
    output logic        error,
    output tilelink_a   bus_tla,
    input  tilelink_d   bus_tld
);

    localparam int CW = $clog2(TIMEOUT + 1);
    // Last wait-counter value before the abort fires: TIMEOUT cycles in WAIT.
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        WR_WAIT,
        FINISH
    } state_t;

    state_t        state, next;
    logic [31:0]   src, dst, hold;
    logic [15:0]   remaining;
    logic [CW-1:0] wait_cnt;
    logic          error_q;

    logic in_wait, d_ok, d_bad, timed_out, a_fire;

    assign in_wait   = (state == RD_WAIT) || (state == WR_WAIT);
    assign d_ok      = in_wait && bus_tld.d_valid && !bus_tld.d_error;
    assign d_bad     = in_wait && bus_tld.d_valid &&  bus_tld.d_error;
    assign timed_out = in_wait && !bus_tld.d_valid && (wait_cnt == WAIT_LAST);
    assign a_fire    = bus_tla.a_valid && bus_tld.d_ready;

    // Fields the engine does not need to inspect.
    logic unused_ok;
    assign unused_ok = ^{src_addr[1:0], dst_addr[1:0], bus_tld.d_opcode,
                         bus_tld.d_param, bus_tld.d_size, bus_tld.d_source};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            src       <= '0;
            dst       <= '0;
            hold      <= '0;
            remaining <= '0;
            wait_cnt  <= '0;
            error_q   <= 1'b0;
        end else begin
            state <= next;

            case (state)
                IDLE: if (start) begin
                    src       <= {src_addr[31:2], 2'b00};
                    dst       <= {dst_addr[31:2], 2'b00};
                    remaining <= word_count;
                    error_q   <= 1'b0;
                end
                RD_WAIT: if (d_ok) hold <= bus_tld.d_data;
                WR_WAIT: if (d_ok) begin
                    src       <= src + 32'd4;
                    dst       <= dst + 32'd4;
                    remaining <= remaining - 16'd1;
                end
                default: ;
            endcase

            if (d_bad || timed_out)
                error_q <= 1'b1;

            // Every WAIT is entered from a REQ state, so clearing there
            // gives a fresh count on each WAIT entry.
            if (state == RD_REQ || state == WR_REQ)
                wait_cnt <= '0;
            else if (in_wait)
                wait_cnt <= wait_cnt + CW'(1);
        end
    end

    always_comb begin
        next             = state;
        bus_tla          = '0;
        bus_tla.a_ready  = 1'b1;
        busy             = (state != IDLE);
        done             = (state == FINISH);

        case (state)
            IDLE: if (start)
                next = (word_count == 16'd0) ? FINISH : RD_REQ;
            RD_REQ: begin
                bus_tla.a_valid   = 1'b1;
                bus_tla.a_opcode  = OP_GET;
                bus_tla.a_size    = 3'd2;
                bus_tla.a_mask    = 4'hF;
                bus_tla.a_address = src;
                if (a_fire) next = RD_WAIT;
            end
            RD_WAIT: begin
                if (d_bad || timed_out) next = FINISH;
                else if (d_ok)          next = WR_REQ;
            end
            WR_REQ: begin
                bus_tla.a_valid   = 1'b1;
                bus_tla.a_opcode  = OP_PUT_FULL;
                bus_tla.a_size    = 3'd2;
                bus_tla.a_mask    = 4'hF;
                bus_tla.a_address = dst;
                bus_tla.a_data    = hold;
                if (a_fire) next = WR_WAIT;
            end
            WR_WAIT: begin
                if (d_bad || timed_out) next = FINISH;
                else if (d_ok)          next = (remaining == 16'd1) ? FINISH : RD_REQ;
            end
            FINISH:  next = IDLE;
            default: next = IDLE;
        endcase
    end

    assign error = error_q;

endmodule

// File: tb/tb_tl_copy_engine.sv
// Bench for tl_copy_engine: a small RAM responder on the bus, a scoreboard
// of expected A beats and expected done/error outcomes, and a monitor that
// pops and compares whenever the DUT presents an accepted beat or a done.

module tb_tl_copy_engine;
    import tl_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] src_addr = '0;
    logic [31:0] dst_addr = '0;
    logic [15:0] word_count = '0;
    logic        busy, done, error;
    tilelink_a   tla;
    tilelink_d   tld;

    always #5 clock = ~clock;

    tl_copy_engine #(.TIMEOUT(255)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .bus_tla    (tla),
        .bus_tld    (tld)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        bit          has_data;
    } beat_t;

    beat_t beat_q[$];
    bit    done_q[$];   // expected error value at each done pulse

    logic [31:0] ram [0:63];

    // Responder knobs, written only by the main process.
    bit no_resp = 0;    // never answer a Get
    bit err_wr  = 0;    // answer Put with d_error=1 and do not write
    bit hold_wr = 0;    // write on Put but never answer
    int stall_cfg = 0;
    int stall_gen = 0;
    int late_req  = 0;

    task automatic push_get(input logic [31:0] a);
        beat_t b;
        b.op = OP_GET; b.addr = a; b.data = '0; b.has_data = 0;
        beat_q.push_back(b);
    endtask

    task automatic push_put(input logic [31:0] a, input logic [31:0] d);
        beat_t b;
        b.op = OP_PUT_FULL; b.addr = a; b.data = d; b.has_data = 1;
        beat_q.push_back(b);
    endtask

    // Responder: answers the cycle after acceptance.
    initial begin : responder
        bit          pend;
        logic [31:0] rdata;
        logic        rerr;
        logic [2:0]  rop;
        logic [5:0]  idx;
        int          seen_gen, late_ack, stall_left;
        pend = 0; rdata = '0; rerr = 0; rop = '0;
        seen_gen = 0; late_ack = 0; stall_left = 0;
        tld = '0;
        tld.d_ready = 1'b1;
        forever begin
            @(negedge clock);
            tld.d_valid = 1'b0;
            tld.d_error = 1'b0;
            if (pend) begin
                tld.d_valid  = 1'b1;
                tld.d_data   = rdata;
                tld.d_error  = rerr;
                tld.d_opcode = rop;
                pend = 0;
            end else if (late_req != late_ack) begin
                late_ack++;
                tld.d_valid = 1'b1;
                tld.d_data  = 32'hBAD0BAD0;
            end
            if (stall_gen != seen_gen) begin
                seen_gen   = stall_gen;
                stall_left = stall_cfg;
            end
            if (tla.a_valid && stall_left > 0) begin
                tld.d_ready = 1'b0;
                stall_left--;
            end else begin
                tld.d_ready = 1'b1;
            end
            if (tla.a_valid && tld.d_ready && reset_n) begin
                idx = tla.a_address[7:2];
                if (tla.a_opcode == OP_GET) begin
                    rdata = ram[idx]; rerr = 0; rop = 3'd1; pend = !no_resp;
                end else if (err_wr) begin
                    rdata = '0; rerr = 1; rop = 3'd0; pend = 1;
                end else begin
                    ram[idx] = tla.a_data;
                    rdata = '0; rerr = 0; rop = 3'd0; pend = !hold_wr;
                end
            end
        end
    end

    // Monitor: compares accepted A beats and done pulses against the queues,
    // and checks that a stalled A beat holds steady.
    initial begin : monitor
        bit          prev_stall;
        logic [31:0] prev_addr;
        beat_t       e;
        bit          eerr;
        prev_stall = 0;
        prev_addr  = '0;
        forever begin
            @(negedge clock);
            #1;
            if (prev_stall) begin
                check("stall_a_valid", 32'(tla.a_valid), 32'd1);
                check("stall_a_address", tla.a_address, prev_addr);
            end
            prev_stall = tla.a_valid && !tld.d_ready;
            prev_addr  = tla.a_address;
            if (tla.a_valid && tld.d_ready) begin
                if (beat_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL beat: unexpected A beat op=%0d addr=%h, none required", tla.a_opcode, tla.a_address);
                end else begin
                    e = beat_q.pop_front();
                    check("beat_opcode", 32'(tla.a_opcode), 32'(e.op));
                    check("beat_address", tla.a_address, e.addr);
                    check("beat_mask", 32'(tla.a_mask), 32'hF);
                    check("beat_size", 32'(tla.a_size), 32'd2);
                    if (e.has_data) check("beat_data", tla.a_data, e.data);
                end
            end else if (!tla.a_valid) begin
                check("idle_mask", 32'(tla.a_mask), 32'd0);
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL done: unexpected done pulse, none required");
                end else begin
                    eerr = done_q.pop_front();
                    check("done_error", 32'(error), 32'(eerr));
                end
            end
        end
    end

    // Issues one copy and watches it to completion. The start cycle counts
    // as cycle 1; busy/done are sampled once per cycle after the monitor.
    task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                            input int stray, output int bcyc, output int dcyc, output int dcnt);
        int  cyc;
        bit  ended;
        bcyc = 0; dcyc = 0; dcnt = 0; ended = 0;
        @(negedge clock);
        src_addr = s; dst_addr = d; word_count = n; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        cyc = 2;
        for (int k = 0; k < 2000; k++) begin
            #2;
            if (busy) bcyc++;
            if (done) begin dcnt++; dcyc = cyc; end
            if (!busy) begin ended = 1; break; end
            @(negedge clock);
            cyc++;
            if (stray != 0 && cyc == stray) begin
                start = 1'b1; src_addr = 32'h0000_0080; dst_addr = 32'h0000_00F0; word_count = 16'd3;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        if (!ended) begin
            total++; bad++;
            $display("FAIL copy_bound: busy still %0d after 2000 cycles, required 0", busy);
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, required finished", $time);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int  b, dc, dn;
        bit  found;
        for (int i = 0; i < 64; i++) ram[i] = 32'hDEAD0000 | 32'(i);
        ram[0] = 32'h11; ram[1] = 32'h22; ram[2] = 32'h33; ram[3] = 32'h44;

        // Reset state.
        repeat (3) @(negedge clock);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_a_valid", 32'(tla.a_valid), 32'd0);
        check("rst_a_mask", 32'(tla.a_mask), 32'd0);
        check("rst_a_ready", 32'(tla.a_ready), 32'd1);
        @(negedge clock);
        reset_n = 1'b1;

        // Four-word copy; dst low bits are ignored; a stray start mid-copy
        // must not disturb it. 4 words x 4 cycles + FINISH = 17 busy cycles.
        for (int i = 0; i < 4; i++) begin
            push_get(32'(4 * i));
            push_put(32'h40 + 32'(4 * i), 32'h11 * 32'(i + 1));
        end
        done_q.push_back(0);
        run_copy(32'h0, 32'h43, 16'd4, 5, b, dc, dn);
        check("copy4_busy_cycles", 32'(b), 32'd17);
        check("copy4_done_count", 32'(dn), 32'd1);
        check("copy4_done_cycle", 32'(dc), 32'd18);
        check("copy4_ram16", ram[16], 32'h11);
        check("copy4_ram17", ram[17], 32'h22);
        check("copy4_ram18", ram[18], 32'h33);
        check("copy4_ram19", ram[19], 32'h44);
        check("copy4_error", 32'(error), 32'd0);

        // Zero-length copy: straight to FINISH, done in cycle 2.
        done_q.push_back(0);
        run_copy(32'h10, 32'h20, 16'd0, 0, b, dc, dn);
        check("zero_done_count", 32'(dn), 32'd1);
        check("zero_done_cycle", 32'(dc), 32'd2);
        check("zero_busy_cycles", 32'(b), 32'd1);
        check("zero_error", 32'(error), 32'd0);

        // Error on the first write aborts; destination untouched.
        err_wr = 1;
        push_get(32'h0);
        push_put(32'h80, 32'h11);
        done_q.push_back(1);
        run_copy(32'h0, 32'h80, 16'd2, 0, b, dc, dn);
        err_wr = 0;
        check("werr_error", 32'(error), 32'd1);
        check("werr_done_count", 32'(dn), 32'd1);
        check("werr_busy_cycles", 32'(b), 32'd5);
        check("werr_ram32", ram[32], 32'hDEAD0020);

        // No read response: 1 RD_REQ + 255 RD_WAIT + FINISH.
        no_resp = 1;
        push_get(32'h8);
        done_q.push_back(1);
        run_copy(32'h8, 32'h90, 16'd1, 0, b, dc, dn);
        no_resp = 0;
        check("tmo_busy_cycles", 32'(b), 32'd257);
        check("tmo_error", 32'(error), 32'd1);
        done_q.push_back(0);
        run_copy(32'h0, 32'h0, 16'd0, 0, b, dc, dn);
        check("tmo_error_cleared", 32'(error), 32'd0);

        // A-channel stall of 5 cycles during RD_REQ.
        stall_cfg = 5;
        stall_gen++;
        push_get(32'hC);
        push_put(32'hC0, 32'h44);
        done_q.push_back(0);
        run_copy(32'hC, 32'hC0, 16'd1, 0, b, dc, dn);
        check("stall_busy_cycles", 32'(b), 32'd10);
        check("stall_ram48", ram[48], 32'h44);

        // Reset during WR_WAIT, then a late D beat.
        hold_wr = 1;
        push_get(32'h4);
        push_put(32'hC4, 32'h22);
        @(negedge clock);
        src_addr = 32'h4; dst_addr = 32'hC4; word_count = 16'd1; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        found = 0;
        for (int k = 0; k < 50; k++) begin
            #2;
            if (tla.a_valid && tla.a_opcode == OP_PUT_FULL && tld.d_ready) begin
                found = 1;
                break;
            end
            @(negedge clock);
        end
        check("rstmid_put_seen", 32'(found), 32'd1);
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("rstmid_a_valid", 32'(tla.a_valid), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        hold_wr = 0;
        late_req++;
        repeat (5) @(negedge clock);
        #2;
        check("rstmid_busy_after", 32'(busy), 32'd0);
        check("rstmid_error_after", 32'(error), 32'd0);
        check("rstmid_ram49", ram[49], 32'h22);

        check("beats_left", 32'(beat_q.size()), 32'd0);
        check("dones_left", 32'(done_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
